// File: rtl/fmadd_align_add_normalize.sv
// Align/add/normalize stage of the fused multiply-add: orders two unpacked finite operands,
// aligns the smaller one bit-serially with guard/round/sticky, adds or subtracts, then normalizes.
module fmadd_align_add_normalize #(
  parameter int std = 31,
  parameter int man = 22,
  parameter int exp = 7
) (
  input  logic             clk,
  input  logic             rst_l,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_A_sign,
  input  logic [exp:0]     in_A_exp,
  input  logic [man+1:0]   in_A_man,
  input  logic             in_B_sign,
  input  logic [exp:0]     in_B_exp,
  input  logic [man+1:0]   in_B_man,
  input  logic             in_NX_flag_Mul,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [man+1:0]   out_Mantissa,
  output logic [exp+1:0]   out_Exponent,
  output logic             out_Sign,
  output logic             out_Guard,
  output logic             out_Round,
  output logic             out_Sticky,
  output logic             out_A_eq_B,
  output logic             out_NX_flag_Mul,
  output logic [2:0]       dbg_state
);

  // Handshake: a transfer happens on a rising edge where valid and ready are both high.
  // in_ready is high only in IDLE; out_valid only in DONE, with outputs frozen until out_ready.

  localparam int WW = man + 5;  // {mantissa, G, R, S}
  localparam int RW = man + 6;  // {carry, mantissa, G, R, S}
  localparam logic [exp:0]   C_ONE = (exp+1)'(1);
  localparam logic [exp:0]   C_MAX = (exp+1)'(man + 4);
  localparam logic [exp+1:0] E_ONE = (exp+2)'(1);

  if (std != man + exp + 2) begin : g_param_check
    $error("std must equal man + exp + 2");
  end

  typedef enum logic [2:0] {IDLE, ALIGN, ADD, NORM, DONE} state_t;
  state_t state, state_nxt;

  logic           l_sign, s_sign;
  logic [man+1:0] l_man;
  logic [exp:0]   l_exp;
  logic [WW-1:0]  w;
  logic [exp:0]   cnt;

  logic [exp:0]   a_eff, b_eff;
  logic           a_is_l;
  logic [RW-1:0]  res;
  logic           res_zero;
  logic           norm_done;

  always_comb begin
    a_eff     = (in_A_exp == '0) ? C_ONE : in_A_exp;
    b_eff     = (in_B_exp == '0) ? C_ONE : in_B_exp;
    a_is_l    = {a_eff, in_A_man} >= {b_eff, in_B_man};
    // Ordering by magnitude guarantees the subtraction never goes negative.
    res       = (l_sign ^ s_sign) ? ({1'b0, l_man, 3'b000} - {1'b0, w})
                                  : ({1'b0, l_man, 3'b000} + {1'b0, w});
    res_zero  = (res == '0);
    norm_done = out_Mantissa[man+1] | (out_Exponent <= E_ONE);
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid)  state_nxt = ALIGN;
      ALIGN:   if (cnt == '0) state_nxt = ADD;
      ADD:     state_nxt = res_zero ? DONE : NORM;
      NORM:    if (norm_done) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
    dbg_state = state;
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      l_sign          <= 1'b0;
      s_sign          <= 1'b0;
      l_man           <= '0;
      l_exp           <= '0;
      w               <= '0;
      cnt             <= '0;
      out_Mantissa    <= '0;
      out_Exponent    <= '0;
      out_Sign        <= 1'b0;
      out_Guard       <= 1'b0;
      out_Round       <= 1'b0;
      out_Sticky      <= 1'b0;
      out_A_eq_B      <= 1'b0;
      out_NX_flag_Mul <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          out_NX_flag_Mul <= in_NX_flag_Mul;
          if (a_is_l) begin
            l_sign <= in_A_sign; s_sign <= in_B_sign;
            l_man  <= in_A_man;  l_exp  <= a_eff;
            w      <= {in_B_man, 3'b000};
            cnt    <= a_eff - b_eff;
          end else begin
            l_sign <= in_B_sign; s_sign <= in_A_sign;
            l_man  <= in_B_man;  l_exp  <= b_eff;
            w      <= {in_A_man, 3'b000};
            cnt    <= b_eff - a_eff;
          end
        end
        ALIGN: if (cnt != '0) begin
          // Beyond man+4 positions every bit lands in sticky, so collapse in one step.
          if (cnt > C_MAX) begin
            w   <= {{(WW-1){1'b0}}, |w};
            cnt <= '0;
          end else begin
            w   <= {1'b0, w[WW-1:2], w[1] | w[0]};
            cnt <= cnt - C_ONE;
          end
        end
        ADD: begin
          out_Sign <= l_sign;
          if (res_zero) begin
            out_A_eq_B   <= 1'b1;
            out_Mantissa <= '0;
            out_Exponent <= '0;
            out_Guard    <= 1'b0;
            out_Round    <= 1'b0;
            out_Sticky   <= 1'b0;
          end else if (res[RW-1]) begin
            out_A_eq_B   <= 1'b0;
            out_Mantissa <= res[RW-1:4];
            out_Guard    <= res[3];
            out_Round    <= res[2];
            out_Sticky   <= res[1] | res[0];
            out_Exponent <= {1'b0, l_exp} + E_ONE;
          end else begin
            out_A_eq_B   <= 1'b0;
            out_Mantissa <= res[RW-2:3];
            out_Guard    <= res[2];
            out_Round    <= res[1];
            out_Sticky   <= res[0];
            out_Exponent <= {1'b0, l_exp};
          end
        end
        NORM: if (!norm_done) begin
          out_Mantissa <= {out_Mantissa[man:0], out_Guard};
          out_Guard    <= out_Round;
          out_Round    <= 1'b0;
          out_Exponent <= out_Exponent - E_ONE;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fmadd_align_add_normalize.sv
// Bench for fmadd_align_add_normalize: directed corner cases plus random operand pairs,
// checked against a wide-shift reference model through an expected-result queue.
module tb_fmadd_align_add_normalize;

  logic        clk = 1'b0;
  logic        rst_l;
  logic        in_valid, in_ready;
  logic        in_A_sign, in_B_sign, in_NX_flag_Mul;
  logic [7:0]  in_A_exp, in_B_exp;
  logic [23:0] in_A_man, in_B_man;
  logic        out_valid, out_ready;
  logic [23:0] out_Mantissa;
  logic [8:0]  out_Exponent;
  logic        out_Sign, out_Guard, out_Round, out_Sticky, out_A_eq_B, out_NX_flag_Mul;
  logic [2:0]  dbg_state;

  fmadd_align_add_normalize dut (
    .clk(clk), .rst_l(rst_l),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_A_sign(in_A_sign), .in_A_exp(in_A_exp), .in_A_man(in_A_man),
    .in_B_sign(in_B_sign), .in_B_exp(in_B_exp), .in_B_man(in_B_man),
    .in_NX_flag_Mul(in_NX_flag_Mul),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_Mantissa(out_Mantissa), .out_Exponent(out_Exponent), .out_Sign(out_Sign),
    .out_Guard(out_Guard), .out_Round(out_Round), .out_Sticky(out_Sticky),
    .out_A_eq_B(out_A_eq_B), .out_NX_flag_Mul(out_NX_flag_Mul),
    .dbg_state(dbg_state)
  );

  typedef struct packed {
    logic [23:0] m;
    logic [8:0]  e;
    logic        sg, g, r, s, eq, nx;
    logic [7:0]  lat;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   failed = 0;
  int   cyc = 0;
  int   accept_cyc = 0;
  logic seen = 1'b0;

  // clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    tests++;
    if (got !== want) begin
      failed++;
      $display("FAIL %s: got %0h want %0h", tag, got, want);
    end
  endtask

  // Reference: align with one wide shift, OR everything below R into sticky.
  function automatic exp_t model(input logic as, input logic [7:0] ae, input logic [23:0] am,
                                 input logic bs, input logic [7:0] be, input logic [23:0] bm,
                                 input logic nx);
    exp_t        x;
    logic [7:0]  ea, eb, el, es;
    logic [23:0] lm, sm;
    logic        ls, ss;
    logic [26:0] w;
    logic [58:0] wide;
    logic [27:0] r;
    int          d, align, n;
    ea = (ae == 0) ? 8'd1 : ae;
    eb = (be == 0) ? 8'd1 : be;
    if ({ea, am} >= {eb, bm}) begin
      el = ea; lm = am; ls = as; es = eb; sm = bm; ss = bs;
    end else begin
      el = eb; lm = bm; ls = bs; es = ea; sm = am; ss = as;
    end
    d = int'(el) - int'(es);
    if (d > 26) begin
      w = {26'd0, |sm};
      align = 2;
    end else begin
      wide = {sm, 3'b000, 32'd0} >> d;
      w = wide[58:32];
      w[0] = w[0] | (|wide[31:0]);
      align = d + 1;
    end
    r = (ls ^ ss) ? ({1'b0, lm, 3'b000} - {1'b0, w}) : ({1'b0, lm, 3'b000} + {1'b0, w});
    x = '0;
    x.sg = ls;
    x.nx = nx;
    if (r == 0) begin
      x.eq  = 1'b1;
      x.lat = 8'(align + 1);
    end else begin
      if (r[27]) begin
        x.m = r[27:4]; x.g = r[3]; x.r = r[2]; x.s = r[1] | r[0]; x.e = {1'b0, el} + 9'd1;
      end else begin
        x.m = r[26:3]; x.g = r[2]; x.r = r[1]; x.s = r[0]; x.e = {1'b0, el};
      end
      n = 1;
      while (!x.m[23] && x.e > 1) begin
        x.m = {x.m[22:0], x.g}; x.g = x.r; x.r = 1'b0; x.e = x.e - 9'd1; n++;
      end
      x.lat = 8'(align + 1 + n);
    end
    return x;
  endfunction

  // scoreboard: compare on the first cycle each result becomes valid
  always @(negedge clk) begin
    if (rst_l && out_valid && !seen) begin
      exp_t e;
      seen = 1'b1;
      if (exp_q.size() == 0) begin
        check("unexpected_result", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check("mantissa", out_Mantissa, e.m);
        check("exponent", out_Exponent, e.e);
        check("sign", out_Sign, e.sg);
        check("grs", {out_Guard, out_Round, out_Sticky}, {e.g, e.r, e.s});
        check("a_eq_b", out_A_eq_B, e.eq);
        check("nx", out_NX_flag_Mul, e.nx);
        check("latency", cyc - accept_cyc, e.lat);
      end
    end
    if (!out_valid) seen = 1'b0;
  end

  task automatic send_op(input logic as, input logic [7:0] ae, input logic [23:0] am,
                         input logic bs, input logic [7:0] be, input logic [23:0] bm,
                         input logic nx);
    int k = 0;
    @(negedge clk);
    while (!in_ready && k < 100) begin @(negedge clk); k++; end
    check("ready_before_op", in_ready, 1'b1);
    in_A_sign = as; in_A_exp = ae; in_A_man = am;
    in_B_sign = bs; in_B_exp = be; in_B_man = bm;
    in_NX_flag_Mul = nx;
    in_valid = 1'b1;
    exp_q.push_back(model(as, ae, am, bs, be, bm, nx));
    @(posedge clk);
    #1;
    accept_cyc = cyc;
    in_valid = 1'b0;
    check("busy_after_accept", in_ready, 1'b0);
  endtask

  task automatic wait_empty();
    int k = 0;
    while (exp_q.size() != 0 && k < 300) begin @(negedge clk); k++; end
    check("result_timeout", exp_q.size() == 0, 1'b1);
  endtask

  task automatic run_op(input logic as, input logic [7:0] ae, input logic [23:0] am,
                        input logic bs, input logic [7:0] be, input logic [23:0] bm,
                        input logic nx);
    send_op(as, ae, am, bs, be, bm, nx);
    wait_empty();
  endtask

  initial begin
    rst_l = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_A_sign = 0; in_A_exp = 0; in_A_man = 0;
    in_B_sign = 0; in_B_exp = 0; in_B_man = 0; in_NX_flag_Mul = 0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_state", dbg_state, 3'd0);
    check("rst_outputs", {out_Mantissa, out_Exponent, out_Sign, out_Guard, out_Round,
                          out_Sticky, out_A_eq_B, out_NX_flag_Mul}, '0);
    @(negedge clk) rst_l = 1'b1;

    // directed corner cases
    run_op(0, 8'h7F, 24'h800000, 0, 8'h7F, 24'h800000, 0);  // 1+1, carry
    run_op(0, 8'h7F, 24'h800000, 1, 8'h7F, 24'h800000, 1);  // exact cancellation
    run_op(0, 8'h7F, 24'h800000, 0, 8'h67, 24'h800000, 0);  // d=24, guard only
    run_op(0, 8'h7F, 24'h800000, 0, 8'h61, 24'h800000, 0);  // d=30, collapse to sticky
    run_op(0, 8'h7F, 24'h800000, 1, 8'h7E, 24'hC00000, 0);  // 1-0.75, two shifts
    run_op(0, 8'h7F, 24'h800000, 0, 8'h65, 24'h800001, 1);  // d=26 boundary
    run_op(1, 8'h64, 24'h900000, 0, 8'h7F, 24'hA00000, 0);  // B larger
    run_op(0, 8'hFF, 24'h800000, 0, 8'hFF, 24'h800000, 0);  // exponent overflow bit
    run_op(0, 8'h01, 24'h800000, 1, 8'h00, 24'h400000, 0);  // stops at exp 1, subnormal
    run_op(0, 8'h00, 24'h000000, 0, 8'h00, 24'h000000, 0);  // zero plus zero

    // backpressure
    out_ready = 1'b0;
    send_op(0, 8'h7F, 24'h800000, 0, 8'h7F, 24'h800000, 1);
    wait_empty();
    repeat (5) begin
      @(negedge clk);
      check("bp_valid", out_valid, 1'b1);
      check("bp_in_ready", in_ready, 1'b0);
      check("bp_hold", {out_Mantissa, out_Exponent}, {24'h800000, 9'h080});
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp_release_valid", out_valid, 1'b0);
    check("bp_release_ready", in_ready, 1'b1);

    // reset mid-ALIGN
    send_op(0, 8'h7F, 24'h800000, 0, 8'h6B, 24'h800000, 1);
    repeat (4) @(posedge clk);
    #1;
    check("abort_in_align", dbg_state, 3'd1);
    #2 rst_l = 1'b0;
    #1;
    exp_q.delete();
    check("abort_out_valid", out_valid, 1'b0);
    check("abort_in_ready", in_ready, 1'b1);
    check("abort_outputs", {out_Mantissa, out_Exponent, out_Sign, out_Guard, out_Round,
                            out_Sticky, out_A_eq_B, out_NX_flag_Mul}, '0);
    @(negedge clk) rst_l = 1'b1;
    run_op(0, 8'h7F, 24'h800000, 0, 8'h7F, 24'h800000, 0);

    // random operand pairs
    for (int i = 0; i < 40; i++) begin
      logic [7:0]  ae, be;
      logic [23:0] am, bm;
      int t;
      ae = ($urandom_range(0, 9) == 0) ? 8'd0 : 8'($urandom_range(1, 254));
      t  = int'(ae) + int'($urandom_range(0, 40)) - 20;
      be = (t < 0) ? 8'd0 : (t > 255) ? 8'd255 : 8'(t);
      am = {ae != 0, 23'($urandom)};
      bm = {be != 0, 23'($urandom)};
      if ($urandom_range(0, 5) == 0) bm = am;
      run_op(1'($urandom), ae, am, 1'($urandom), be, bm, 1'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
